// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle byte shift/rotate unit; ports clk, rst (async high), start/op/amount/din request in, busy/done/dout/carry/zero out
module shift_sequencer #(
  parameter int DW   = 8,
  parameter int CNTW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [CNTW-1:0] amount,
  input  logic [DW-1:0]   din,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   dout,
  output logic            carry,
  output logic            zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] d_q, d_d, dout_q, dout_d, s;
  logic [2:0] op_q, op_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, zero_q, zero_d, sc;
  always_comb begin
    case (op_q)
      3'd0:    {sc, s} = {d_q[DW-1], d_q[DW-2:0], 1'b0};
      3'd1:    {sc, s} = {d_q[DW-1], d_q[DW-2:0], d_q[DW-1]};
      3'd2:    {sc, s} = {d_q[0], 1'b0, d_q[DW-1:1]};
      3'd3:    {sc, s} = {d_q[0], d_q[0], d_q[DW-1:1]};
      3'd5:    {sc, s} = {d_q[DW-1], d_q[DW-2:0], 1'b1};
      3'd6:    {sc, s} = {d_q[0], 1'b1, d_q[DW-1:1]};
      default: {sc, s} = {1'b0, d_q};
    endcase
  end
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (start) begin
        d_d     = din;
        op_d    = op;
        cnt_d   = amount;
        state_d = (amount == '0) ? DONE : SHIFT;
        if (amount == '0) begin
          dout_d  = din;
          carry_d = 1'b0;
          zero_d  = (din == '0);
        end
      end
      SHIFT: begin
        d_d   = s;
        cnt_d = (cnt_q == CNTW'(1)) ? cnt_q : cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = DONE;
          dout_d  = s;
          carry_d = sc;
          zero_d  = (s == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign dout  = dout_q;
  assign carry = carry_q;
  assign zero  = zero_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven, corner-case and randomized checks of shift_sequencer
module tb_shift_sequencer;
  logic clk = 0, rst = 1, start = 0, busy, done, carry, zero;
  logic [2:0] op = 0, amount = 0;
  logic [7:0] din = 0, dout;
  int tests = 0, fails = 0;

  shift_sequencer #(.DW(8), .CNTW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount), .din(din),
    .busy(busy), .done(done), .dout(dout), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] din;
    logic [2:0] amt;
    logic [7:0] dout;
    logic       carry;
    logic       zero;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_model(input int o, input int di, input int a);
    int v, c;
    v = di;
    c = 0;
    for (int k = 0; k < a; k++) begin
      case (o)
        0: begin c = v / 128; v = (v * 2) % 256; end
        1: begin c = v / 128; v = (v * 2) % 256 + c; end
        2: begin c = v % 2; v = v / 2; end
        3: begin c = v % 2; v = v / 2 + c * 128; end
        5: begin c = v / 128; v = (v * 2) % 256 + 1; end
        6: begin c = v % 2; v = v / 2 + 128; end
        default: c = 0;
      endcase
    end
    return {c[0], v[7:0]};
  endfunction

  task automatic do_req(input logic [2:0] o, input logic [7:0] di, input logic [2:0] a,
                        input logic [7:0] ed, input logic ec, input logic ez);
    int lat, bc;
    logic [7:0] prev;
    prev = dout;
    lat = -1;
    bc = 0;
    @(negedge clk);
    start = 1; op = o; din = di; amount = a;
    @(posedge clk);
    #1;
    start = 0; op = 3'($urandom); din = 8'($urandom); amount = 3'($urandom);
    for (int i = 0; i < 12 && lat < 0; i++) begin
      @(negedge clk);
      bc += int'(busy);
      if (done) begin
        lat = i;
        chk("dout", dout, ed);
        chk("carry", carry, ec);
        chk("zero", zero, ez);
      end else chk("dout_hold", dout, prev);
    end
    chk("latency", lat, a);
    chk("busy_cycles", bc, a + 1);
    @(negedge clk);
    chk("idle_after", {busy, done}, 0);
  endtask

  vec_t tbl[10];
  int dcnt, first_i, second_i;
  logic [8:0] r;
  logic [2:0] ro, ra;
  logic [7:0] rd;

  initial begin
    tbl[0] = '{3'd3, 8'h01, 3'd1, 8'h80, 1'b1, 1'b0};
    tbl[1] = '{3'd1, 8'h81, 3'd3, 8'h0C, 1'b0, 1'b0};
    tbl[2] = '{3'd0, 8'hFF, 3'd7, 8'h80, 1'b1, 1'b0};
    tbl[3] = '{3'd2, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{3'd3, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{3'd4, 8'hA5, 3'd6, 8'hA5, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 8'h00, 3'd4, 8'hF0, 1'b0, 1'b0};
    tbl[7] = '{3'd5, 8'h00, 3'd3, 8'h07, 1'b0, 1'b0};
    tbl[8] = '{3'd1, 8'h80, 3'd1, 8'h01, 1'b1, 1'b0};
    tbl[9] = '{3'd7, 8'h3C, 3'd2, 8'h3C, 1'b0, 1'b0};
    @(negedge clk);
    chk("reset_state", {busy, done, dout, carry, zero}, 0);
    rst = 0;
    for (int i = 0; i < 10; i++)
      do_req(tbl[i].op, tbl[i].din, tbl[i].amt, tbl[i].dout, tbl[i].carry, tbl[i].zero);
    // abort mid-shift with asynchronous reset; previous result 3C must be cleared
    @(negedge clk);
    start = 1; op = 3'd1; din = 8'h81; amount = 3'd5;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1 chk("abort_state", {busy, done, dout, carry, zero}, 0);
    @(negedge clk);
    rst = 0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_dout", dout, 0);
    // start held high: second accept only in the IDLE cycle after DONE
    @(negedge clk);
    start = 1; op = 3'd6; din = 8'h00; amount = 3'd4;
    @(posedge clk);
    #1 din = 8'h3C;
    dcnt = 0; first_i = -1; second_i = -1;
    for (int i = 0; i < 20 && second_i < 0; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (first_i < 0) begin
          first_i = i;
          chk("held_dout1", dout, 8'hF0);
          chk("held_carry1", carry, 0);
        end else begin
          second_i = i;
          start = 0;
          chk("held_dout2", dout, 8'hF3);
          chk("held_carry2", carry, 1);
        end
      end
    end
    chk("held_first_lat", first_i, 4);
    chk("held_second_lat", second_i, 10);
    chk("held_done_count", dcnt, 2);
    start = 0;
    @(negedge clk);
    chk("held_idle", busy, 0);
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom);
      rd = 8'($urandom);
      ra = 3'($urandom_range(0, 7));
      r = ref_model(ro, rd, ra);
      do_req(ro, rd, ra, r[7:0], r[8], r[7:0] == 8'h00);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
